contador_programa: RTL and testbench
====================================

# contador_programa

Program-counter and sequencing stage of the single-cycle processor; it sits directly downstream of the control unit and feeds the instruction-memory address. It consumes the control unit's flow-control outputs (Jr, Jump, Branch, BranchNE, OpIn, OpHalt) together with the ALU zero flag, and computes and registers the next PC. It owns the processor's run/wait/halt state machine, gates architectural writes while the core stalls on an IN instruction, and counts retired instructions.

## Interface
- LARGURA_PC, 10, instruction-memory word-address width
- LARGURA_IMED, 16, branch offset width, signed, in words
- LARGURA_ALVO, 26, jump target field width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous reset, active-low
- Jr, Jump, Branch, BranchNE, OpIn, OpHalt  in  1 each  flow-control outputs of the control unit
- zero  in  1  ALU zero flag for the current instruction
- imediato  in  LARGURA_IMED  branch offset
- alvo  in  LARGURA_ALVO  jump target field
- reg_jr  in  32  register value for jr
- entrada_valida  in  1  input device confirm, already synchronized, level or pulse
- continuar  in  1  resume request from halt
- pc  out  LARGURA_PC  current instruction address
- pc_mais1  out  LARGURA_PC  pc+1 mod 2^LARGURA_PC, combinational
- libera_escrita  out  1  qualifies EscreveReg/EscreveMem this cycle, combinational
- esperando_entrada  out  1  core stalled on IN, registered
- parado  out  1  core halted, registered
- instrucoes  out  32  retired-instruction count, registered

## Operation
- States: EXECUTA, ESPERA_ENTRADA, PARADO.
- Next PC in EXECUTA uses this priority:
  - Jr → reg_jr[LARGURA_PC-1:0]
  - Jump → alvo[LARGURA_PC-1:0]
  - Branch & zero → pc+1+sext(imediato)
  - BranchNE & !zero → pc+1+sext(imediato)
  - otherwise pc+1
- All PC arithmetic is modulo 2^LARGURA_PC. Truncation is silent.
- The imediato offset is sign-extended to LARGURA_PC before the add.
- EXECUTA:
  - OpHalt → PC holds, go to PARADO. OpHalt has top priority over every other control input.
  - Else OpIn & !entrada_valida → PC holds, go to ESPERA_ENTRADA.
  - Else (including OpIn & entrada_valida) → PC takes the next-PC value and the state stays EXECUTA.
- ESPERA_ENTRADA:
  - PC holds.
  - On entrada_valida: PC ← pc+1, go to EXECUTA.
- PARADO:
  - PC holds.
  - On continuar: PC ← pc+1, go to EXECUTA.
- libera_escrita:
  - 1 in EXECUTA when OpIn=0.
  - 1 in EXECUTA or ESPERA_ENTRADA when OpIn=1 and entrada_valida=1.
  - 0 in every other case, including all of PARADO and while reset_n=0.
- instrucoes increments by 1 on every edge where an instruction completes:
  - each PC update, and
  - entry into PARADO (the halt instruction retires).
  - It wraps 2^32−1 → 0.
- Ignored inputs:
  - entrada_valida when not in an IN instruction.
  - continuar outside PARADO.
- Jr and Jump both high is illegal; Jr still wins.

## Timing
- Reset values (reset_n low, asynchronous): pc=0, state EXECUTA, esperando_entrada=0, parado=0, instrucoes=0, libera_escrita=0.
- Reset mid-wait or mid-halt → same values; execution restarts at address 0.
- PC, state, parado, esperando_entrada and instrucoes update on the rising clock edge.
- Each instruction takes 1 cycle, except IN, which takes 1 + the number of cycles waited.
- esperando_entrada and parado assert on the edge that enters the state and deassert on the edge that leaves it.
- libera_escrita is Mealy and valid in the same cycle as its inputs, so the register file writes IN data on the edge where entrada_valida is seen.
- PC wrap example: pc=2^LARGURA_PC−1 with no flow control → next pc=0.

## Structure
- Shared package holds:
  - state encoding: EXECUTA=2'd0, ESPERA_ENTRADA=2'd1, PARADO=2'd2
  - default widths LARGURA_PC, LARGURA_IMED, LARGURA_ALVO
- Sub-module calculo_proximo_pc: purely combinational next-PC priority mux and adder, reused later for jal.
- contador_programa keeps the FSM, PC register, and counter.

## Test plan
- Reset: run 5 instructions, pull reset_n low asynchronously between edges → pc=0, parado=0, esperando_entrada=0, instrucoes=0 immediately.
- Branches:
  - pc=5, Branch=1, zero=1, imediato=−3 → pc=3.
  - Repeat with zero=0 → pc=6.
  - pc=5, BranchNE=1, zero=0, imediato=+10 → pc=16.
- Priority and wrap:
  - Jr=1, Jump=1, Branch=1, zero=1, reg_jr=0x0123 → pc=0x123.
  - pc=1023 with no control → pc=0.
- IN stall (pc=7, OpIn=1):
  - entrada_valida low 4 cycles → pc=7, esperando_entrada=1, libera_escrita=0.
  - entrada_valida high 1 cycle → libera_escrita=1 that cycle, pc=8 next edge, instrucoes+1.
- Halt (pc=20, OpHalt=1, Jump=1):
  - → pc stays 20, parado=1, libera_escrita=0, instrucoes+1.
  - 3 idle cycles → pc stays 20 and instrucoes is unchanged.
  - continuar pulse → pc=21, parado=0.
- Counter wrap: preload instrucoes near 2^32−1, retire 2 instructions → count reaches 0, then 1.

Source files
------------

// File: rtl/contador_programa_pkg.sv
// Shared definitions for the program-counter / sequencing stage.
//   - Default widths of the PC, the branch offset and the jump target field.
//   - Encoding of the run / wait-for-input / halt state machine.
package contador_programa_pkg;

    localparam int LARGURA_PC   = 10;  // instruction-memory word address
    localparam int LARGURA_IMED = 16;  // signed branch offset, in words
    localparam int LARGURA_ALVO = 26;  // jump target field

    typedef enum logic [1:0] {
        EXECUTA        = 2'd0,
        ESPERA_ENTRADA = 2'd1,
        PARADO         = 2'd2
    } estado_t;

endpackage

// File: rtl/contador_programa_calculo_proximo_pc.sv
// calculo_proximo_pc: purely combinational next-PC selection.
// Ports:
//   pc          in   current PC
//   Jr, Jump, Branch, BranchNE, zero   in   flow-control decode and ALU zero
//   imediato    in   signed branch offset (words)
//   alvo        in   jump target field
//   reg_jr      in   register value for jr
//   pc_mais1    out  pc+1, modulo 2^LARGURA_PC
//   proximo_pc  out  selected next PC (Jr > Jump > taken branch > pc+1)
module calculo_proximo_pc
    import contador_programa_pkg::*;
#(
    parameter int LARGURA_PC   = contador_programa_pkg::LARGURA_PC,
    parameter int LARGURA_IMED = contador_programa_pkg::LARGURA_IMED,
    parameter int LARGURA_ALVO = contador_programa_pkg::LARGURA_ALVO
) (
    input  logic [LARGURA_PC-1:0]   pc,
    input  logic                    Jr,
    input  logic                    Jump,
    input  logic                    Branch,
    input  logic                    BranchNE,
    input  logic                    zero,
    input  logic [LARGURA_IMED-1:0] imediato,
    input  logic [LARGURA_ALVO-1:0] alvo,
    input  logic [31:0]             reg_jr,
    output logic [LARGURA_PC-1:0]   pc_mais1,
    output logic [LARGURA_PC-1:0]   proximo_pc
);

    // Offset sign-extended to 32 bits; only the low LARGURA_PC bits matter
    // since all PC arithmetic wraps modulo 2^LARGURA_PC.
    logic [31:0]           imed_ext;
    logic [LARGURA_PC-1:0] alvo_desvio;
    logic                  desvio_tomado;

    always_comb begin
        imed_ext      = {{(32-LARGURA_IMED){imediato[LARGURA_IMED-1]}}, imediato};
        pc_mais1      = pc + LARGURA_PC'(1);
        alvo_desvio   = pc_mais1 + imed_ext[LARGURA_PC-1:0];
        desvio_tomado = (Branch & zero) | (BranchNE & ~zero);

        proximo_pc = pc_mais1;
        if (Jr) begin
            proximo_pc = reg_jr[LARGURA_PC-1:0];
        end else if (Jump) begin
            proximo_pc = alvo[LARGURA_PC-1:0];
        end else if (desvio_tomado) begin
            proximo_pc = alvo_desvio;
        end
    end

endmodule

// File: rtl/contador_programa.sv
// contador_programa: PC register, run/wait/halt FSM and retired-instruction
// counter of the single-cycle core.
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   Jr, Jump, Branch, BranchNE, OpIn, OpHalt   control-unit flow outputs
//   zero                  ALU zero flag
//   imediato, alvo, reg_jr  branch offset, jump field, jr register value
//   entrada_valida        input-device confirm (synchronized)
//   continuar             resume request while halted
//   pc, pc_mais1          current PC and pc+1
//   libera_escrita        Mealy write-enable qualifier for reg file / memory
//   esperando_entrada     registered: stalled on IN
//   parado                registered: halted
//   instrucoes            registered retired-instruction count
module contador_programa
    import contador_programa_pkg::*;
#(
    parameter int LARGURA_PC   = contador_programa_pkg::LARGURA_PC,
    parameter int LARGURA_IMED = contador_programa_pkg::LARGURA_IMED,
    parameter int LARGURA_ALVO = contador_programa_pkg::LARGURA_ALVO
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    Jr,
    input  logic                    Jump,
    input  logic                    Branch,
    input  logic                    BranchNE,
    input  logic                    OpIn,
    input  logic                    OpHalt,
    input  logic                    zero,
    input  logic [LARGURA_IMED-1:0] imediato,
    input  logic [LARGURA_ALVO-1:0] alvo,
    input  logic [31:0]             reg_jr,
    input  logic                    entrada_valida,
    input  logic                    continuar,
    output logic [LARGURA_PC-1:0]   pc,
    output logic [LARGURA_PC-1:0]   pc_mais1,
    output logic                    libera_escrita,
    output logic                    esperando_entrada,
    output logic                    parado,
    output logic [31:0]             instrucoes
);

    estado_t               estado_q, estado_d;
    logic [LARGURA_PC-1:0] pc_q, pc_d;
    logic [31:0]           instrucoes_q, instrucoes_d;
    logic [LARGURA_PC-1:0] proximo_pc;
    logic                  retira;

    calculo_proximo_pc #(
        .LARGURA_PC   (LARGURA_PC),
        .LARGURA_IMED (LARGURA_IMED),
        .LARGURA_ALVO (LARGURA_ALVO)
    ) u_calculo (
        .pc         (pc_q),
        .Jr         (Jr),
        .Jump       (Jump),
        .Branch     (Branch),
        .BranchNE   (BranchNE),
        .zero       (zero),
        .imediato   (imediato),
        .alvo       (alvo),
        .reg_jr     (reg_jr),
        .pc_mais1   (pc_mais1),
        .proximo_pc (proximo_pc)
    );

    // Next-state, next-PC and retire decision. OpHalt outranks everything.
    // A halt retires on entry to PARADO; every PC update also retires one.
    always_comb begin
        estado_d       = estado_q;
        pc_d           = pc_q;
        retira         = 1'b0;
        libera_escrita = 1'b0;

        unique case (estado_q)
            EXECUTA: begin
                libera_escrita = ~OpIn | entrada_valida;
                if (OpHalt) begin
                    estado_d       = PARADO;
                    retira         = 1'b1;
                    libera_escrita = 1'b0;
                end else if (OpIn && !entrada_valida) begin
                    estado_d = ESPERA_ENTRADA;
                end else begin
                    pc_d   = proximo_pc;
                    retira = 1'b1;
                end
            end
            ESPERA_ENTRADA: begin
                libera_escrita = OpIn & entrada_valida;
                if (entrada_valida) begin
                    estado_d = EXECUTA;
                    pc_d     = pc_mais1;
                    retira   = 1'b1;
                end
            end
            PARADO: begin
                if (continuar) begin
                    estado_d = EXECUTA;
                    pc_d     = pc_mais1;
                    retira   = 1'b1;
                end
            end
            default: begin
                estado_d = EXECUTA;
            end
        endcase

        // Writes are never released while the core is held in reset.
        if (!reset_n) begin
            libera_escrita = 1'b0;
        end

        instrucoes_d = retira ? instrucoes_q + 32'd1 : instrucoes_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= EXECUTA;
            pc_q         <= '0;
            instrucoes_q <= '0;
        end else begin
            estado_q     <= estado_d;
            pc_q         <= pc_d;
            instrucoes_q <= instrucoes_d;
        end
    end

    assign pc                = pc_q;
    assign instrucoes        = instrucoes_q;
    assign esperando_entrada = (estado_q == ESPERA_ENTRADA);
    assign parado            = (estado_q == PARADO);

endmodule

// File: tb/tb_contador_programa.sv
// Directed bench for contador_programa with hand-computed expectations.
module tb_contador_programa;
    import contador_programa_pkg::*;

    logic                    clock;
    logic                    reset_n;
    logic                    Jr, Jump, Branch, BranchNE, OpIn, OpHalt, zero;
    logic [LARGURA_IMED-1:0] imediato;
    logic [LARGURA_ALVO-1:0] alvo;
    logic [31:0]             reg_jr;
    logic                    entrada_valida, continuar;
    logic [LARGURA_PC-1:0]   pc, pc_mais1;
    logic                    libera_escrita, esperando_entrada, parado;
    logic [31:0]             instrucoes;

    int unsigned n_aval   = 0;
    int unsigned n_falhas = 0;
    logic [31:0] exp_instr;

    contador_programa dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .Jr                (Jr),
        .Jump              (Jump),
        .Branch            (Branch),
        .BranchNE          (BranchNE),
        .OpIn              (OpIn),
        .OpHalt            (OpHalt),
        .zero              (zero),
        .imediato          (imediato),
        .alvo              (alvo),
        .reg_jr            (reg_jr),
        .entrada_valida    (entrada_valida),
        .continuar         (continuar),
        .pc                (pc),
        .pc_mais1          (pc_mais1),
        .libera_escrita    (libera_escrita),
        .esperando_entrada (esperando_entrada),
        .parado            (parado),
        .instrucoes        (instrucoes)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obtido,
                            input logic [31:0] esperado);
        n_aval++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: obtido=0x%0h esperado=0x%0h", tag, obtido, esperado);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic limpa();
        Jr = 0; Jump = 0; Branch = 0; BranchNE = 0; OpIn = 0; OpHalt = 0;
        zero = 0; imediato = '0; alvo = '0; reg_jr = '0;
        entrada_valida = 0; continuar = 0;
    endtask

    task automatic salta(input logic [31:0] destino);
        limpa();
        Jump = 1;
        alvo = LARGURA_ALVO'(destino);
        tick();
        exp_instr = exp_instr + 32'd1;
        verifica("salto_pc", 32'(pc), destino);
        limpa();
    endtask

    task automatic verifica_zerado(input string tag);
        verifica({tag, "_pc"}, 32'(pc), 32'd0);
        verifica({tag, "_parado"}, 32'(parado), 32'd0);
        verifica({tag, "_espera"}, 32'(esperando_entrada), 32'd0);
        verifica({tag, "_instr"}, instrucoes, 32'd0);
        verifica({tag, "_libera"}, 32'(libera_escrita), 32'd0);
    endtask

    initial begin
        limpa();
        reset_n = 0;
        exp_instr = 0;
        #2;
        verifica_zerado("reset_inicial");
        #10;
        reset_n = 1;

        // Five sequential instructions, then asynchronous reset mid-cycle.
        for (int i = 1; i <= 5; i++) begin
            tick();
            verifica("seq_pc", 32'(pc), 32'(i));
            verifica("seq_pc_mais1", 32'(pc_mais1), 32'(i + 1));
        end
        verifica("seq_instr", instrucoes, 32'd5);
        #2;
        reset_n = 0;
        #1;
        verifica_zerado("reset_assinc");
        #1;
        reset_n = 1;
        exp_instr = 0;

        // Branch taken backwards: 5 + 1 - 3 = 3
        salta(5);
        Branch = 1; zero = 1; imediato = -16'sd3;
        tick(); exp_instr++;
        verifica("beq_tomado", 32'(pc), 32'd3);
        // Branch not taken: 6
        salta(5);
        Branch = 1; zero = 0; imediato = -16'sd3;
        tick(); exp_instr++;
        verifica("beq_nao_tomado", 32'(pc), 32'd6);
        // BranchNE taken forward: 5 + 1 + 10 = 16
        salta(5);
        BranchNE = 1; zero = 0; imediato = 16'sd10;
        tick(); exp_instr++;
        verifica("bne_tomado", 32'(pc), 32'd16);
        // BranchNE with zero=1 not taken: 17
        limpa();
        BranchNE = 1; zero = 1; imediato = 16'sd10;
        tick(); exp_instr++;
        verifica("bne_nao_tomado", 32'(pc), 32'd17);

        // Priority: Jr beats Jump and branch
        limpa();
        Jr = 1; Jump = 1; Branch = 1; zero = 1;
        reg_jr = 32'hFFFF_0123; alvo = 26'd7; imediato = 16'sd4;
        tick(); exp_instr++;
        verifica("prioridade_jr", 32'(pc), 32'h123);
        // Jump beats branch
        limpa();
        Jump = 1; Branch = 1; zero = 1; alvo = 26'h3FF_FC05; imediato = 16'sd4;
        tick(); exp_instr++;
        verifica("prioridade_jump", 32'(pc), 32'h005);

        // PC wrap
        salta(1023);
        verifica("wrap_pc_mais1", 32'(pc_mais1), 32'd0);
        tick(); exp_instr++;
        verifica("wrap_pc", 32'(pc), 32'd0);
        // Backwards branch wraps below zero: 0 + 1 - 3 = 1022
        Branch = 1; zero = 1; imediato = -16'sd3;
        tick(); exp_instr++;
        verifica("wrap_desvio", 32'(pc), 32'd1022);
        verifica("instr_ate_aqui", instrucoes, exp_instr);

        // IN with data already valid: no stall
        salta(30);
        OpIn = 1; entrada_valida = 1;
        #1;
        verifica("in_direto_libera", 32'(libera_escrita), 32'd1);
        tick(); exp_instr++;
        verifica("in_direto_pc", 32'(pc), 32'd31);
        verifica("in_direto_espera", 32'(esperando_entrada), 32'd0);

        // IN stall at pc=7
        salta(7);
        OpIn = 1; entrada_valida = 0;
        #1;
        verifica("in_libera_exec", 32'(libera_escrita), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            verifica("in_espera_pc", 32'(pc), 32'd7);
            verifica("in_espera_flag", 32'(esperando_entrada), 32'd1);
            verifica("in_espera_libera", 32'(libera_escrita), 32'd0);
        end
        verifica("in_espera_instr", instrucoes, exp_instr);
        entrada_valida = 1;
        #1;
        verifica("in_valida_libera", 32'(libera_escrita), 32'd1);
        tick(); exp_instr++;
        verifica("in_fim_pc", 32'(pc), 32'd8);
        verifica("in_fim_espera", 32'(esperando_entrada), 32'd0);
        verifica("in_fim_instr", instrucoes, exp_instr);

        // Halt at pc=20 with Jump also asserted
        salta(20);
        OpHalt = 1; Jump = 1; alvo = 26'd99;
        #1;
        verifica("halt_libera_exec", 32'(libera_escrita), 32'd0);
        tick(); exp_instr++;
        verifica("halt_pc", 32'(pc), 32'd20);
        verifica("halt_parado", 32'(parado), 32'd1);
        verifica("halt_libera", 32'(libera_escrita), 32'd0);
        verifica("halt_instr", instrucoes, exp_instr);
        limpa();
        // Idle while halted; entrada_valida and an IN decode must be ignored
        OpIn = 1; entrada_valida = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            verifica("parado_pc", 32'(pc), 32'd20);
            verifica("parado_instr", instrucoes, exp_instr);
            verifica("parado_libera", 32'(libera_escrita), 32'd0);
        end
        limpa();
        continuar = 1;
        tick(); exp_instr++;
        continuar = 0;
        verifica("continua_pc", 32'(pc), 32'd21);
        verifica("continua_parado", 32'(parado), 32'd0);
        verifica("continua_instr", instrucoes, exp_instr);
        // continuar outside PARADO is ignored: plain pc+1
        continuar = 1;
        tick(); exp_instr++;
        continuar = 0;
        verifica("continuar_ignorado", 32'(pc), 32'd22);

        // Reset while halted
        OpHalt = 1;
        tick();
        limpa();
        verifica("halt2_parado", 32'(parado), 32'd1);
        #2;
        reset_n = 0;
        #1;
        verifica_zerado("reset_parado");
        #1;
        reset_n = 1;

        // Counter wrap from preloaded all-ones
        tick();
        force dut.instrucoes_q = 32'hFFFF_FFFF;
        #1;
        release dut.instrucoes_q;
        #1;
        verifica("contador_pre", instrucoes, 32'hFFFF_FFFF);
        tick();
        verifica("contador_wrap0", instrucoes, 32'd0);
        tick();
        verifica("contador_wrap1", instrucoes, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
        $finish;
    end

endmodule
